mac_accumulator: RTL and testbench

- Sequencing and accumulation stage that drives the combinational 16x16+32 signed multiply-add block (o = c +- a*b).
- Accepts a stream of product terms, one per cycle, and feeds the running 32-bit sum back as the c operand.
- On the last term of a group, scales and saturates the sum to a 16-bit result and presents it on a valid/ready output.
- Used by filter and mixer paths to evaluate dot products on a single DSP tile.

---
 rtl/mac_accumulator.sv | 87 ++++++++
 tb/tb_mac_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Purpose: sequences product terms into an external 16x16+32 multiply-add and accumulates a scaled, saturated dot product.
// Latency: the result is valid one cycle after the last term of a group is accepted. A new result can load every cycle.
// Backpressure: term_ready drops while a result is pending and out_ready is low. The source must then hold its term stable.
module mac_accumulator #(
    parameter int                 SHIFT = 15,
    parameter logic signed [31:0] BIAS  = 32'sd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        term_valid,
    output logic        term_ready,
    input  logic [15:0] term_a,
    input  logic [15:0] term_b,
    input  logic        term_sub,
    input  logic        term_last,
    output logic [31:0] mac_c,
    output logic        mac_s,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    input  logic [31:0] mac_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_clip,
    output logic [7:0]  out_count
);

    logic signed [31:0] acc;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;
    logic               term_fire;
    logic signed [31:0] scaled;
    logic               clip_hi;
    logic               clip_lo;
    logic [15:0]        sat_data;

    // The operands go straight to the multiply-add block. Its result comes back through mac_o in the same cycle.
    assign mac_a = term_a;
    assign mac_b = term_b;
    assign mac_s = term_sub;
    assign mac_c = acc;

    assign term_ready = !out_valid || out_ready;
    assign term_fire  = term_valid && term_ready;

    assign cnt_inc = (cnt == 8'd255) ? 8'd255 : cnt + 8'd1;

    assign scaled  = $signed(mac_o) >>> SHIFT;
    assign clip_hi = scaled > 32'sd32767;
    assign clip_lo = scaled < -32'sd32768;

    always_comb begin
        sat_data = scaled[15:0];
        if (clip_hi) begin
            sat_data = 16'h7fff;
        end else if (clip_lo) begin
            sat_data = 16'h8000;
        end
    end

    // Ignoring mac_o unless a term fires keeps undriven term inputs out of acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= BIAS;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_clip  <= 1'b0;
            out_count <= 8'd0;
        end else if (term_fire) begin
            if (term_last) begin
                acc       <= BIAS;
                cnt       <= 8'd0;
                out_data  <= sat_data;
                out_clip  <= clip_hi || clip_lo;
                out_count <= cnt_inc;
                out_valid <= 1'b1;
            end else begin
                acc <= $signed(mac_o);
                cnt <= cnt_inc;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator. It contains an ideal multiply-add block, a group-level reference model, and directed and random stimulus.
module tb_mac_accumulator;
    localparam int                 SHIFT = 15;
    localparam logic signed [31:0] BIAS  = 32'sd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        term_valid = 1'b0;
    logic        term_ready;
    logic [15:0] term_a = 16'd0;
    logic [15:0] term_b = 16'd0;
    logic        term_sub = 1'b0;
    logic        term_last = 1'b0;
    logic [31:0] mac_c;
    logic        mac_s;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [31:0] mac_o;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_clip;
    logic [7:0]  out_count;

    always #5 clk = ~clk;

    mac_accumulator #(.SHIFT(SHIFT), .BIAS(BIAS)) dut (
        .clk(clk), .rst_n(rst_n),
        .term_valid(term_valid), .term_ready(term_ready),
        .term_a(term_a), .term_b(term_b), .term_sub(term_sub), .term_last(term_last),
        .mac_c(mac_c), .mac_s(mac_s), .mac_a(mac_a), .mac_b(mac_b), .mac_o(mac_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_clip(out_clip), .out_count(out_count)
    );

    // The multiply-add tile: o = c +- a*b, with a 32-bit wrap.
    logic signed [31:0] tile_prod;
    assign tile_prod = $signed(mac_a) * $signed(mac_b);
    assign mac_o = mac_s ? mac_c - tile_prod : mac_c + tile_prod;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the running group sum, the term count, and the last published result.
    int m_acc, m_cnt, m_data, m_count;
    bit m_valid, m_clip, fired;

    function automatic void model_reset();
        m_acc = BIAS; m_cnt = 0; m_valid = 0; m_data = 0; m_clip = 0; m_count = 0;
    endfunction

    function automatic void model_update();
        int p, s, r;
        fired = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fired = term_valid && (!m_valid || out_ready);
        if (fired) begin
            p = int'($signed(term_a)) * int'($signed(term_b));
            s = term_sub ? m_acc - p : m_acc + p;
            if (term_last) begin
                r = s >>> SHIFT;
                m_clip  = (r > 32767) || (r < -32768);
                m_data  = (r > 32767) ? 32767 : (r < -32768) ? -32768 : r;
                m_count = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                m_valid = 1;
                m_acc   = BIAS;
                m_cnt   = 0;
            end else begin
                m_acc = s;
                m_cnt = m_cnt + 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("term_ready", term_ready, (!m_valid || out_ready));
            chk("mac_c", $signed(mac_c), m_acc);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_data", $signed(out_data), m_data);
                chk("out_clip", out_clip, m_clip);
                chk("out_count", out_count, m_count);
            end
            if (term_valid) begin
                chk("mac_pass", {mac_s, mac_a, mac_b}, {term_sub, term_a, term_b});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input int a, input int b, input bit sub, input bit last);
        term_a = a[15:0]; term_b = b[15:0]; term_sub = sub; term_last = last;
        term_valid = 1'b1;
        fired = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fired) break;
        end
        if (!fired) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: term not accepted within 100 cycles");
        end
        term_valid = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0: return 16'h8000;
            1: return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_term_ready_low", term_ready, 1);
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_term_ready", term_ready, 1);
        chk("rst_mac_c", $signed(mac_c), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_clip", out_clip, 0);

        send(16384, 16384, 0, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", $signed(out_data), 8192);
        chk("single_clip", out_clip, 0);
        chk("single_count", out_count, 1);
        chk("single_mac_c", $signed(mac_c), 0);
        step();

        send(16384, 16384, 0, 0);
        send(16384, 8192, 1, 0);
        chk("three_partial", $signed(mac_c), 134217728);
        send(8192, 8192, 0, 1);
        chk("three_data", $signed(out_data), 6144);
        chk("three_count", out_count, 3);
        step();

        send(32767, 32767, 0, 0);
        send(32767, 32767, 0, 1);
        chk("satpos_data", $signed(out_data), 32767);
        chk("satpos_clip", out_clip, 1);
        step();

        send(-32768, 32767, 0, 0);
        send(-32768, 32767, 0, 1);
        chk("satneg_data", $signed(out_data), -32768);
        chk("satneg_clip", out_clip, 1);
        step();

        out_ready = 1'b0;
        send(-32768, 32767, 0, 1);
        chk("negone_data", $signed(out_data), -32767);
        chk("negone_clip", out_clip, 0);
        term_a = 16'd16384; term_b = 16'd16384; term_sub = 1'b0; term_last = 1'b1;
        term_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_term_ready", term_ready, 0);
            chk("bp_out_data", $signed(out_data), -32767);
            chk("bp_mac_c", $signed(mac_c), 0);
        end
        out_ready = 1'b1;
        step();
        term_valid = 1'b0;
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_data", $signed(out_data), 8192);
        step();

        send(16384, 16384, 0, 0);
        send(16384, 16384, 0, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_mac_c", $signed(mac_c), 0);
        rst_n = 1'b1;
        send(16384, 16384, 0, 1);
        chk("midrst_data", $signed(out_data), 8192);
        chk("midrst_count", out_count, 1);
        step();

        for (int i = 0; i < 299; i++) send(16384, 1, 0, 0);
        send(16384, 1, 0, 1);
        chk("long_count", out_count, 255);
        chk("long_data", $signed(out_data), 150);
        step();

        fired = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!(term_valid && !fired)) begin
                term_valid = ($urandom_range(0, 9) < 7);
                term_a     = rnd16();
                term_b     = rnd16();
                term_sub   = 1'($urandom);
                term_last  = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        term_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
